// File: rtl/duck_sprite_drawer.sv
`default_nettype none
// ============================================================================
// Module   : duck_sprite_drawer
// Brief    : Erases the duck's previous 8x8 box, then plots the 8x8 sprite at
//            the new position, one clipped pixel write per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module duck_sprite_drawer #(
    parameter logic [63:0] SPRITE_MASK   = 64'h183C_7EFF_FF7E_3C18,
    parameter logic [2:0]  SPRITE_COLOUR = 3'b110,
    parameter logic [2:0]  BG_COLOUR     = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       erase_only,
    input  logic [7:0] new_x,
    input  logic [6:0] new_y,
    output logic       busy,
    output logic       done,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       plot
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ERASE  = 2'd1;
    localparam logic [1:0] S_DRAW   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [8:0] X_LIMIT = 9'd160;
    localparam logic [7:0] Y_LIMIT = 8'd120;

    logic [1:0] state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] old_x_q;
    logic [6:0] old_y_q;
    logic       valid_q;
    logic [7:0] req_x_q;
    logic [6:0] req_y_q;
    logic       req_erase_only_q;

    logic [7:0] x_out_q, x_out_d;
    logic [6:0] y_out_q, y_out_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       w_accept;
    logic [7:0] w_base_x;
    logic [6:0] w_base_y;
    logic [8:0] w_sum_x;
    logic [7:0] w_sum_y;
    logic       w_in_range;

    // FINISH accepts a new request exactly like IDLE, giving back-to-back runs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_accept = 1'b0;
        case (state_q)
            S_IDLE, S_FINISH: begin
                state_d = S_IDLE;
                if (start) begin
                    w_accept = 1'b1;
                    cnt_d    = 6'd0;
                    if (valid_q) begin
                        state_d = S_ERASE;
                    end else if (!erase_only) begin
                        state_d = S_DRAW;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_ERASE: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = req_erase_only_q ? S_FINISH : S_DRAW;
                end
            end
            S_DRAW: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = S_FINISH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the state being entered so they are registered
    // yet the first pixel still appears in the cycle right after acceptance.
    always_comb begin
        w_base_x = req_x_q;
        w_base_y = req_y_q;
        if (state_d == S_ERASE) begin
            w_base_x = old_x_q;
            w_base_y = old_y_q;
        end else if (w_accept) begin
            w_base_x = new_x;
            w_base_y = new_y;
        end

        w_sum_x    = {1'b0, w_base_x} + {6'd0, cnt_d[2:0]};
        w_sum_y    = {1'b0, w_base_y} + {5'd0, cnt_d[5:3]};
        w_in_range = (w_sum_x < X_LIMIT) && (w_sum_y < Y_LIMIT);

        x_out_d  = x_out_q;
        y_out_d  = y_out_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        case (state_d)
            S_ERASE: begin
                x_out_d  = w_sum_x[7:0];
                y_out_d  = w_sum_y[6:0];
                colour_d = BG_COLOUR;
                plot_d   = w_in_range;
            end
            S_DRAW: begin
                x_out_d  = w_sum_x[7:0];
                y_out_d  = w_sum_y[6:0];
                colour_d = SPRITE_COLOUR;
                plot_d   = w_in_range & SPRITE_MASK[cnt_d];
            end
            default: ;
        endcase

        busy_d = (state_d == S_ERASE) || (state_d == S_DRAW);
        done_d = (state_d == S_FINISH);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            cnt_q            <= 6'd0;
            old_x_q          <= 8'd0;
            old_y_q          <= 7'd0;
            valid_q          <= 1'b0;
            req_x_q          <= 8'd0;
            req_y_q          <= 7'd0;
            req_erase_only_q <= 1'b0;
            x_out_q          <= 8'd0;
            y_out_q          <= 7'd0;
            colour_q         <= 3'd0;
            plot_q           <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_out_q  <= x_out_d;
            y_out_q  <= y_out_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;

            if (w_accept) begin
                req_x_q          <= new_x;
                req_y_q          <= new_y;
                req_erase_only_q <= erase_only;
            end

            // Any path into FINISH other than from DRAW is an erase-only request.
            if (state_d == S_FINISH) begin
                if (state_q == S_DRAW) begin
                    old_x_q <= req_x_q;
                    old_y_q <= req_y_q;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign x_out  = x_out_q;
    assign y_out  = y_out_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_duck_sprite_drawer.sv
`default_nettype none
// ============================================================================
// Module   : tb_duck_sprite_drawer
// Brief    : Table-driven requests with a per-cycle scoreboard of pixel writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_duck_sprite_drawer;

    logic       clock;
    logic       reset;
    logic       start;
    logic       erase_only;
    logic [7:0] new_x;
    logic [6:0] new_y;
    logic       busy;
    logic       done;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       plot;

    duck_sprite_drawer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .erase_only (erase_only),
        .new_x      (new_x),
        .new_y      (new_y),
        .busy       (busy),
        .done       (done),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour     (colour),
        .plot       (plot)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       plot;
        logic [2:0] col;
        logic [6:0] y;
        logic [7:0] x;
    } exp_t;

    // mode: 0 plain, 1 stray start pulse mid-request, 2 start held high throughout
    typedef struct {
        logic       eo;
        logic [7:0] nx;
        logic [6:0] ny;
        int         mode;
        int         exp_done;
        int         exp_plots;
    } vec_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] m_mask  = 64'h183C_7EFF_FF7E_3C18;
    logic        m_valid = 1'b0;
    int          m_old_x = 0;
    int          m_old_y = 0;
    logic [7:0]  last_x  = 8'd0;
    logic [6:0]  last_y  = 7'd0;
    logic [2:0]  last_c  = 3'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_box(input int bx, input int by, input logic is_draw);
        exp_t e;
        int   xs, ys;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                xs     = bx + c;
                ys     = by + r;
                e.busy = 1'b1;
                e.done = 1'b0;
                e.x    = xs[7:0];
                e.y    = ys[6:0];
                e.col  = is_draw ? 3'd6 : 3'd0;
                e.plot = (xs < 160) && (ys < 120) && (is_draw ? m_mask[r*8+c] : 1'b1);
                last_x = e.x;
                last_y = e.y;
                last_c = e.col;
                q.push_back(e);
            end
        end
    endtask

    task automatic model_push(input logic eo, input logic [7:0] nx, input logic [6:0] ny);
        exp_t e;
        if (m_valid) push_box(m_old_x, m_old_y, 1'b0);
        if (!eo) push_box(int'(nx), int'(ny), 1'b1);
        e = {1'b0, 1'b1, 1'b0, last_c, last_y, last_x};
        q.push_back(e);
        if (!eo) begin
            m_old_x = int'(nx);
            m_old_y = int'(ny);
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    // Entered at a negedge with the DUT idle or in its done cycle; returns at
    // the negedge of this request's done cycle.
    task automatic run_req(input vec_t v, input int idx);
        int   done_cyc;
        int   nplot;
        exp_t a;
        exp_t e;
        start      = 1'b1;
        erase_only = v.eo;
        new_x      = v.nx;
        new_y      = v.ny;
        model_push(v.eo, v.nx, v.ny);
        done_cyc = 0;
        nplot    = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            if (k == 1 && v.mode != 2) start = 1'b0;
            if (v.mode == 1 && k == 10) begin
                start      = 1'b1;
                new_x      = 8'd99;
                new_y      = 7'd9;
                erase_only = 1'b1;
            end
            if (v.mode == 1 && k == 11) start = 1'b0;
            a = {busy, done, plot, colour, y_out, x_out};
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL req%0d cyc%0d unexpected output: got 0x%0h expected none", idx, k, a);
            end else begin
                e = q.pop_front();
                chk($sformatf("req%0d cyc%0d pixel", idx, k), 32'(a), 32'(e));
            end
            if (a.plot === 1'b1) nplot++;
            if (a.done === 1'b1) begin
                done_cyc = k;
                break;
            end
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL req%0d early end: got %0d entries left expected 0", idx, q.size());
            q.delete();
        end
        chk($sformatf("req%0d done cycle", idx), 32'(done_cyc), 32'(v.exp_done));
        chk($sformatf("req%0d plot count", idx), 32'(nplot), 32'(v.exp_plots));
    endtask

    vec_t tbl[12];
    exp_t a;

    initial begin
        tbl[0]  = '{1'b0, 8'd10,  7'd20,  0, 65,  40};
        tbl[1]  = '{1'b0, 8'd40,  7'd50,  1, 129, 104};
        tbl[2]  = '{1'b0, 8'd155, 7'd115, 0, 129, 83};
        tbl[3]  = '{1'b1, 8'd0,   7'd0,   0, 65,  25};
        tbl[4]  = '{1'b0, 8'd0,   7'd0,   0, 65,  40};
        tbl[5]  = '{1'b1, 8'd0,   7'd0,   0, 65,  64};
        tbl[6]  = '{1'b1, 8'd5,   7'd5,   0, 1,   0};
        tbl[7]  = '{1'b0, 8'd159, 7'd119, 0, 65,  0};
        tbl[8]  = '{1'b0, 8'd200, 7'd100, 0, 129, 1};
        tbl[9]  = '{1'b0, 8'd156, 7'd126, 2, 129, 0};
        tbl[10] = '{1'b0, 8'd12,  7'd3,   0, 129, 40};
        tbl[11] = '{1'b0, 8'd252, 7'd0,   0, 129, 64};

        reset      = 1'b0;
        start      = 1'b0;
        erase_only = 1'b0;
        new_x      = 8'd0;
        new_y      = 7'd0;
        repeat (3) @(negedge clock);
        a = {busy, done, plot, colour, y_out, x_out};
        chk("reset state", 32'(a), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        a = {busy, done, plot, colour, y_out, x_out};
        chk("idle after reset", 32'(a), 32'd0);

        for (int i = 0; i < 12; i++) run_req(tbl[i], i);

        // Idle outputs hold the last pixel address and colour
        @(negedge clock);
        a = {busy, done, plot, colour, y_out, x_out};
        chk("idle hold", 32'(a), 32'({1'b0, 1'b0, 1'b0, 3'd6, 7'd7, 8'd3}));

        // Reset during cycle 30 of an erase of the box at (252,0)
        start      = 1'b1;
        erase_only = 1'b0;
        new_x      = 8'd20;
        new_y      = 7'd20;
        @(negedge clock);
        start = 1'b0;
        repeat (29) @(negedge clock);
        a = {busy, done, plot, colour, y_out, x_out};
        chk("erase cycle 30", 32'(a), 32'({1'b1, 1'b0, 1'b0, 3'd0, 7'd3, 8'd1}));
        reset = 1'b0;
        #1;
        a = {busy, done, plot, colour, y_out, x_out};
        chk("async reset outputs", 32'(a), 32'd0);
        @(negedge clock);
        reset   = 1'b1;
        m_valid = 1'b0;
        last_x  = 8'd0;
        last_y  = 7'd0;
        last_c  = 3'd0;
        @(negedge clock);
        a = {busy, done, plot, colour, y_out, x_out};
        chk("no done after reset", 32'(a), 32'd0);
        run_req('{1'b0, 8'd70, 7'd60, 0, 65, 40}, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
